// File: rtl/transparency_fade_controller_if.sv
// Fade-command handshake bundle between the control-register side (master)
// and transparency_fade_controller (slave).
interface transparency_fade_controller_if #(
  parameter int TRANSPARENCY_PRECISION = 4,
  parameter int FRAME_COUNT_WIDTH      = 8
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [TRANSPARENCY_PRECISION-1:0] cmd_target;
  logic [TRANSPARENCY_PRECISION-1:0] cmd_step;
  logic [FRAME_COUNT_WIDTH-1:0]      cmd_frames;

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_frames,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_frames,
    output cmd_ready
  );
endinterface

// File: rtl/transparency_fade_controller.sv
// Frame-synchronous ramp of the shared blend proportion toward a commanded target.
// Optional TRANSPARENCY_FADE_RETARGET_EN: accept new commands mid-fade (cmd_ready held high).
module transparency_fade_controller #(
  parameter int TRANSPARENCY_PRECISION = 4,
  parameter int FRAME_COUNT_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  transparency_fade_controller_if.slave     cmd,
  output logic [TRANSPARENCY_PRECISION-1:0] src_a_proportion,
  output logic                              busy,
  output logic                              done
);

  typedef enum logic {IDLE, FADE} state_t;

  localparam int P = TRANSPARENCY_PRECISION;
  localparam int F = FRAME_COUNT_WIDTH;

  state_t         r_state, w_state_nxt;
  logic [P-1:0]   r_prop,   w_prop_nxt;
  logic [P-1:0]   r_target, w_target_nxt;
  logic [P-1:0]   r_step,   w_step_nxt;
  logic [F-1:0]   r_frames, w_frames_nxt;
  logic [F-1:0]   r_count,  w_count_nxt;
  logic           r_done,   w_done_nxt;

  logic           w_accept;
  logic [F-1:0]   w_cmd_frames;
  logic           w_up;
  logic [P:0]     w_diff;

`ifdef TRANSPARENCY_FADE_RETARGET_EN
  assign cmd.cmd_ready = 1'b1;
`else
  assign cmd.cmd_ready = (r_state == IDLE);
`endif

  assign w_accept     = cmd.cmd_valid && cmd.cmd_ready;
  assign w_cmd_frames = (cmd.cmd_frames == '0) ? F'(1) : cmd.cmd_frames;

  // Distance is taken one bit wider so neither direction can wrap.
  assign w_up   = (r_target > r_prop);
  assign w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_prop})
                       : ({1'b0, r_prop} - {1'b0, r_target});

  always_comb begin
    w_state_nxt  = r_state;
    w_prop_nxt   = r_prop;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;
    w_frames_nxt = r_frames;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;

    // An accept wins over a coincident frame_start, so that pulse is not counted.
    if (w_accept) begin
      w_target_nxt = cmd.cmd_target;
      w_step_nxt   = cmd.cmd_step;
      w_frames_nxt = w_cmd_frames;
      w_count_nxt  = w_cmd_frames;
      if (cmd.cmd_target == r_prop) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = FADE;
      end
    end else if (r_state == FADE && frame_start) begin
      if (r_count <= F'(1)) begin
        if (r_step == '0 || w_diff <= {1'b0, r_step}) begin
          w_prop_nxt  = r_target;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_prop_nxt  = w_up ? (r_prop + r_step) : (r_prop - r_step);
          w_count_nxt = r_frames;
        end
      end else begin
        w_count_nxt = r_count - F'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prop   <= '1;
      r_target <= '1;
      r_step   <= '0;
      r_frames <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prop   <= w_prop_nxt;
      r_target <= w_target_nxt;
      r_step   <= w_step_nxt;
      r_frames <= w_frames_nxt;
      r_count  <= w_count_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign src_a_proportion = r_prop;
  assign busy             = (r_state == FADE);
  assign done             = r_done;

endmodule
